alu_cmd_sequencer: RTL and testbench

- Command-side master for the 16-bit ALU. It accepts operation commands over a valid/ready handshake and reads operands from an internal 8x16 register file.
- It drives the ALU's a/b/sel inputs from registers, samples the ALU result one cycle later, writes it back to the register file, and returns a response over a second valid/ready handshake.
- It sits between the instruction/test front-end and the combinational ALU.

---
 rtl/alu_cmd_sequencer_if.sv | 42 ++++
 rtl/alu_cmd_sequencer.sv | 106 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// master: the sequencer itself; slave: the front-end, ALU and response consumer.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
);
    localparam int unsigned AW = $clog2(NREG);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_ld;
    logic [3:0]       cmd_op;
    logic [AW-1:0]    cmd_rd;
    logic [AW-1:0]    cmd_ra;
    logic [AW-1:0]    cmd_rb;
    logic [WIDTH-1:0] cmd_imm;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [AW-1:0]    rsp_rd;
    logic             rsp_zero;
    logic             rsp_err;
    logic [15:0]      op_count;

    modport master (
        input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, alu_out, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_rd, rsp_zero,
               rsp_err, op_count
    );

    modport slave (
        output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, alu_out, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_rd, rsp_zero,
               rsp_err, op_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences load / ALU-op commands against an 8x16 register file and an external
// combinational ALU, returning one response per command.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input logic                 clk,
    input logic                 rst,
    alu_cmd_sequencer_if.master bus_io
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0]    rsp_rd_q, rsp_rd_d;
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      op_count_q, op_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rf_q       <= '{default: '0};
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.cmd_valid) begin
                    // rsp_rd doubles as the latched destination for the CAPTURE write-back
                    rsp_rd_d = bus_io.cmd_rd;
                    if (bus_io.cmd_ld) begin
                        rf_d[bus_io.cmd_rd] = bus_io.cmd_imm;
                        rsp_data_d          = bus_io.cmd_imm;
                        rsp_err_d           = 1'b0;
                        state_d             = StResp;
                    end else begin
                        alu_a_d   = rf_q[bus_io.cmd_ra];
                        alu_b_d   = rf_q[bus_io.cmd_rb];
                        alu_sel_d = bus_io.cmd_op;
                        rsp_err_d = (bus_io.cmd_op >= 4'b1010);
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: state_d = StCapture;
            StCapture: begin
                rf_d[rsp_rd_q] = bus_io.alu_out;
                rsp_data_d     = bus_io.alu_out;
                state_d        = StResp;
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.cmd_ready = (state_q == StIdle);
    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.alu_a     = alu_a_q;
    assign bus_io.alu_b     = alu_b_q;
    assign bus_io.alu_sel   = alu_sel_q;
    assign bus_io.rsp_data  = rsp_data_q;
    assign bus_io.rsp_rd    = rsp_rd_q;
    assign bus_io.rsp_zero  = (rsp_data_q == '0);
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(16), .NREG(8)) bus ();

    alu_cmd_sequencer #(.WIDTH(16), .NREG(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    // Reference combinational ALU
    always_comb begin
        case (bus.alu_sel)
            4'd0, 4'd8: bus.alu_out = bus.alu_a + bus.alu_b;
            4'd1, 4'd9: bus.alu_out = bus.alu_a - bus.alu_b;
            4'd2:       bus.alu_out = ~bus.alu_a;
            4'd3:       bus.alu_out = ~bus.alu_b;
            4'd4:       bus.alu_out = bus.alu_a & bus.alu_b;
            4'd5:       bus.alu_out = bus.alu_a | bus.alu_b;
            4'd6:       bus.alu_out = bus.alu_a ^ bus.alu_b;
            4'd7:       bus.alu_out = ~(bus.alu_a ^ bus.alu_b);
            default:    bus.alu_out = 16'h0000;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus tasks: all start and end at a negedge
    task automatic drive_cmd(input logic ld, input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm);
        bus.cmd_ld    = ld;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input logic ld, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                           output int lat, output logic [3:0] sel_issue);
        drive_cmd(ld, op, rd, ra, rb, imm);
        lat       = -1;
        sel_issue = 4'hx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (n == 1) sel_issue = bus.alu_sel;
            if (bus.rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // Read rN non-destructively via rN <= rN | rN
    task automatic read_reg(input logic [2:0] r, output logic [15:0] v, output int lat);
        logic [3:0] s;
        run_cmd(1'b0, 4'd5, r, r, r, 16'h0, lat, s);
        v = bus.rsp_data;
        finish_rsp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_zero !== 1'b1 || bus.rsp_data !== 16'h0) begin errs++; $display("FAIL rst_rsp_data got=%h zero=%b exp=0000 zero=1", bus.rsp_data, bus.rsp_zero); end
        checks++; if (bus.op_count !== 16'h0) begin errs++; $display("FAIL rst_op_count got=%h exp=0000", bus.op_count); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 36'h0) begin errs++; $display("FAIL rst_alu got=%h/%h/%h exp=0", bus.alu_a, bus.alu_b, bus.alu_sel); end
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_idle_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_add();
        int lat;
        logic [3:0] s;
        run_cmd(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h1234, lat, s);
        checks++; if (lat !== 1) begin errs++; $display("FAIL load_latency got=%0d exp=1", lat); end
        checks++; if (bus.rsp_data !== 16'h1234 || bus.rsp_rd !== 3'd1) begin errs++; $display("FAIL load_rsp got=%h rd=%0d exp=1234 rd=1", bus.rsp_data, bus.rsp_rd); end
        finish_rsp();
        run_cmd(1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0F0F, lat, s);
        finish_rsp();
        run_cmd(1'b0, 4'd0, 3'd3, 3'd1, 3'd2, 16'h0, lat, s);
        checks++; if (lat !== 3) begin errs++; $display("FAIL add_latency got=%0d exp=3", lat); end
        checks++; if (bus.rsp_data !== 16'h2143) begin errs++; $display("FAIL add_data got=%h exp=2143", bus.rsp_data); end
        checks++; if (bus.rsp_rd !== 3'd3 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin errs++; $display("FAIL add_flags got rd=%0d zero=%b err=%b exp rd=3 zero=0 err=0", bus.rsp_rd, bus.rsp_zero, bus.rsp_err); end
        finish_rsp();
        run_cmd(1'b0, 4'd5, 3'd4, 3'd3, 3'd3, 16'h0, lat, s);
        checks++; if (bus.rsp_data !== 16'h2143 || bus.rsp_rd !== 3'd4) begin errs++; $display("FAIL or_readback got=%h rd=%0d exp=2143 rd=4", bus.rsp_data, bus.rsp_rd); end
        finish_rsp();
        checks++; if (bus.op_count !== 16'd4) begin errs++; $display("FAIL add_op_count got=%0d exp=4", bus.op_count); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [3:0] s;
        logic [15:0] v;
        run_cmd(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h0000, lat, s);
        finish_rsp();
        run_cmd(1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0001, lat, s);
        finish_rsp();
        run_cmd(1'b0, 4'd1, 3'd5, 3'd1, 3'd2, 16'h0, lat, s);
        checks++; if (bus.rsp_data !== 16'hFFFF || bus.rsp_zero !== 1'b0) begin errs++; $display("FAIL sub_wrap got=%h zero=%b exp=ffff zero=0", bus.rsp_data, bus.rsp_zero); end
        finish_rsp();
        run_cmd(1'b0, 4'd7, 3'd6, 3'd2, 3'd2, 16'h0, lat, s);
        checks++; if (bus.rsp_data !== 16'hFFFF) begin errs++; $display("FAIL xnor got=%h exp=ffff", bus.rsp_data); end
        finish_rsp();
        run_cmd(1'b0, 4'd6, 3'd6, 3'd2, 3'd2, 16'h0, lat, s);
        checks++; if (bus.rsp_data !== 16'h0000 || bus.rsp_zero !== 1'b1) begin errs++; $display("FAIL xor_zero got=%h zero=%b exp=0000 zero=1", bus.rsp_data, bus.rsp_zero); end
        finish_rsp();
        run_cmd(1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 16'hABCD, lat, s);
        finish_rsp();
        checks++; if (bus.alu_sel !== 4'd6 || bus.alu_a !== 16'h0001 || bus.alu_b !== 16'h0001) begin errs++; $display("FAIL alu_hold got=%h/%h/%h exp=0001/0001/6", bus.alu_a, bus.alu_b, bus.alu_sel); end
        read_reg(3'd0, v, lat);
        checks++; if (v !== 16'hABCD) begin errs++; $display("FAIL r0_writable got=%h exp=abcd", v); end
    endtask

    task automatic test_hazard();
        int lat;
        logic [3:0] s;
        logic [15:0] v;
        run_cmd(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h0003, lat, s);
        finish_rsp();
        run_cmd(1'b0, 4'd0, 3'd1, 3'd1, 3'd1, 16'h0, lat, s);
        checks++; if (bus.rsp_data !== 16'h0006) begin errs++; $display("FAIL hazard_old_operand got=%h exp=0006", bus.rsp_data); end
        finish_rsp();
        read_reg(3'd1, v, lat);
        checks++; if (v !== 16'h0006) begin errs++; $display("FAIL hazard_writeback got=%h exp=0006", v); end
    endtask

    task automatic test_unsupported();
        int lat;
        logic [3:0] s;
        logic [15:0] v;
        run_cmd(1'b1, 4'd0, 3'd7, 3'd0, 3'd0, 16'h5555, lat, s);
        finish_rsp();
        run_cmd(1'b0, 4'hC, 3'd7, 3'd1, 3'd2, 16'h0, lat, s);
        checks++; if (s !== 4'hC) begin errs++; $display("FAIL bad_op_sel got=%h exp=c", s); end
        checks++; if (bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b1 || bus.rsp_zero !== 1'b1) begin errs++; $display("FAIL bad_op_rsp got=%h err=%b zero=%b exp=0000 err=1 zero=1", bus.rsp_data, bus.rsp_err, bus.rsp_zero); end
        finish_rsp();
        read_reg(3'd7, v, lat);
        checks++; if (v !== 16'h0000 || bus.rsp_err !== 1'b0) begin errs++; $display("FAIL bad_op_r7 got=%h err=%b exp=0000 err=0", v, bus.rsp_err); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] s;
        logic [15:0] v;
        logic [15:0] c0;
        c0 = bus.op_count;
        run_cmd(1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h00AA, lat, s);
        drive_cmd(1'b1, 4'd0, 3'd3, 3'd0, 3'd0, 16'h1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00AA) begin errs++; $display("FAIL bp_hold[%0d] got valid=%b data=%h exp valid=1 data=00aa", i, bus.rsp_valid, bus.rsp_data); end
            checks++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.cmd_ready); end
            checks++; if (bus.op_count !== c0) begin errs++; $display("FAIL bp_count[%0d] got=%h exp=%h", i, bus.op_count, c0); end
        end
        bus.cmd_valid = 1'b0;
        finish_rsp();
        checks++; if (bus.op_count !== c0 + 16'd1) begin errs++; $display("FAIL bp_count_inc got=%h exp=%h", bus.op_count, c0 + 16'd1); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.op_count !== c0 + 16'd1) begin errs++; $display("FAIL bp_after got valid=%b ready=%b count=%h exp 0/1/%h", bus.rsp_valid, bus.cmd_ready, bus.op_count, c0 + 16'd1); end
        read_reg(3'd3, v, lat);
        checks++; if (v !== 16'h2143) begin errs++; $display("FAIL bp_no_accept r3 got=%h exp=2143", v); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] v;
        bit seen;
        drive_cmd(1'b0, 4'd0, 3'd3, 3'd1, 3'd2, 16'h0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_hs got ready=%b valid=%b exp 1/0", bus.cmd_ready, bus.rsp_valid); end
        checks++; if (bus.op_count !== 16'h0 || bus.alu_sel !== 4'h0 || bus.alu_a !== 16'h0) begin errs++; $display("FAIL mid_rst_state got count=%h sel=%h a=%h exp 0", bus.op_count, bus.alu_sel, bus.alu_a); end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_rst_no_rsp got=%b exp=0", seen); end
        read_reg(3'd3, v, lat);
        checks++; if (v !== 16'h0000) begin errs++; $display("FAIL mid_rst_r3 got=%h exp=0000", v); end
        // Reset coincident with a handshake wins
        drive_cmd(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h7777);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'h0) begin errs++; $display("FAIL rst_vs_cmd got valid=%b count=%h exp 0/0000", bus.rsp_valid, bus.op_count); end
        read_reg(3'd1, v, lat);
        checks++; if (v !== 16'h0000) begin errs++; $display("FAIL rst_vs_cmd_r1 got=%h exp=0000", v); end
    endtask

    task automatic test_count_wrap();
        int lat;
        logic [3:0] s;
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.op_count_q;
        @(negedge clk);
        checks++; if (bus.op_count !== 16'hFFFF) begin errs++; $display("FAIL count_preset got=%h exp=ffff", bus.op_count); end
        run_cmd(1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0042, lat, s);
        finish_rsp();
        checks++; if (bus.op_count !== 16'h0000) begin errs++; $display("FAIL count_wrap got=%h exp=0000", bus.op_count); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_rd    = 3'd0;
        bus.cmd_ra    = 3'd0;
        bus.cmd_rb    = 3'd0;
        bus.cmd_imm   = 16'h0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_wrap();
        test_hazard();
        test_unsupported();
        test_backpressure();
        test_reset_mid();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
